regfile_sb: RTL and testbench

- Parametrised two-read/one-write general-purpose register file for the pipelined core, successor to the single-cycle register file.
- Adds asynchronous reset of all entries, optional hardwired-zero register 0, and write-to-read bypass.
- Adds a per-register busy scoreboard for hazard detection: decode reserves a destination, writeback releases it, and a flush clears all reservations.
- Sits between decode (read and reserve) and writeback (write and release).

---
 rtl/regfile_sb.sv | 132 +++++++++++++
 tb/tb_regfile_sb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: two-read/one-write register file with a per-register busy
// scoreboard. Decode reads operands and reserves a destination; writeback
// writes the result and releases the reservation; flush drops every
// reservation without touching register contents.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    localparam int AW      = $clog2(NREGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_ok,
    input  logic            flush,
    output logic [AW:0]     busy_cnt
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic             wr_en;
    logic             grant;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [AW:0]      cnt_nxt;

    // Hardwired-zero register 0 makes address 0 a sink: never written.
    function automatic logic is_zero_addr(input logic [AW-1:0] a);
        return HAS_ZERO && (a == '0);
    endfunction

    // One read port: storage, optionally overridden by a same-cycle write,
    // and finally forced to zero for the hardwired register.
    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   a,
        input logic [XLEN-1:0] stored,
        input logic            wen,
        input logic [AW-1:0]   wa,
        input logic [XLEN-1:0] wd
    );
        logic [XLEN-1:0] v;
        v = stored;
        if (HAS_BYP && wen && (wa == a))
            v = wd;
        if (is_zero_addr(a))
            v = '0;
        return v;
    endfunction

    // Hazard flag for one read port. With bypass, a writeback landing this
    // cycle supplies the operand, so the hazard is already resolved.
    function automatic logic busy_port(
        input logic [AW-1:0] a,
        input logic          b,
        input logic          wen,
        input logic [AW-1:0] wa
    );
        logic v;
        v = b;
        if (HAS_BYP && wen && (wa == a))
            v = 1'b0;
        if (is_zero_addr(a))
            v = 1'b0;
        return v;
    endfunction

    // Combinational decode of write, grant and counter deltas.
    always_comb begin
        wr_en  = we3 && !is_zero_addr(a3);
        rsv_ok = !is_zero_addr(rsv_addr)
                 && (!busy[rsv_addr] || (we3 && (a3 == rsv_addr)))
                 && !flush;
        grant  = rsv_en && rsv_ok;
        // A grant only adds a reservation if the register was free; when the
        // same register is released and re-granted the count is unchanged.
        cnt_inc = grant && !busy[rsv_addr];
        cnt_dec = we3 && busy[a3] && !(grant && (rsv_addr == a3));
        cnt_nxt = busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end

    // Read ports and hazard outputs.
    always_comb begin
        rd1   = read_port(a1, regs[a1], wr_en, a3, wd3);
        rd2   = read_port(a2, regs[a2], wr_en, a3, wd3);
        busy1 = busy_port(a1, busy[a1], we3, a3);
        busy2 = busy_port(a2, busy[a2], we3, a3);
    end

    // Register storage: cleared on reset, written from writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[a3] <= wd3;
        end
    end

    // Scoreboard: flush beats everything; otherwise release then grant, so a
    // grant to the register being released leaves it busy for the new producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else if (flush) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (we3)
                busy[a3] <= 1'b0;
            if (grant)
                busy[rsv_addr] <= 1'b1;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  a1, a2, a3, rsv_addr;
    logic [31:0] wd3;
    logic        we3, rsv_en, flush;

    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        busy1, busy2, nb_busy1, nb_busy2;
    logic        rsv_ok, nb_rsv_ok;
    logic [5:0]  busy_cnt, nb_cnt;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .we3(we3), .a3(a3), .wd3(wd3),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(nb_rd1), .rd2(nb_rd2),
        .busy1(nb_busy1), .busy2(nb_busy2), .we3(we3), .a3(a3), .wd3(wd3),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok),
        .flush(flush), .busy_cnt(nb_cnt)
    );

    typedef struct {
        logic        we3;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic [4:0]  a1, a2;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic        flush;
    } in_t;

    typedef struct {
        logic [31:0] rd1, rd2;
        logic        busy1, busy2, rsv_ok;
        logic [5:0]  cnt;
        logic [31:0] nb_rd1;
        logic        nb_busy1;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t        sb[$];
    logic [31:0] m_reg [32];
    bit   [31:0] m_busy;
    logic [5:0]  m_cnt;
    vec_t        tbl [18];

    function automatic vec_t mk(
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [4:0] ra1, input logic [4:0] ra2,
        input logic re, input logic [4:0] ra, input logic fl,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic eb1, input logic eb2, input logic eok,
        input logic [5:0] ecnt, input logic [31:0] enb1, input logic enbb1
    );
        vec_t v;
        v.i.we3 = we; v.i.a3 = wa; v.i.wd3 = wd; v.i.a1 = ra1; v.i.a2 = ra2;
        v.i.rsv_en = re; v.i.rsv_addr = ra; v.i.flush = fl;
        v.e.rd1 = e1; v.e.rd2 = e2; v.e.busy1 = eb1; v.e.busy2 = eb2;
        v.e.rsv_ok = eok; v.e.cnt = ecnt; v.e.nb_rd1 = enb1; v.e.nb_busy1 = enbb1;
        return v;
    endfunction

    function automatic in_t mkin(
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [4:0] ra1, input logic [4:0] ra2,
        input logic re, input logic [4:0] ra, input logic fl
    );
        in_t x;
        x.we3 = we; x.a3 = wa; x.wd3 = wd; x.a1 = ra1; x.a2 = ra2;
        x.rsv_en = re; x.rsv_addr = ra; x.flush = fl;
        return x;
    endfunction

    // Reference model of the combinational outputs from current model state.
    function automatic exp_t model_exp(input in_t x);
        exp_t e;
        logic wr;
        wr = x.we3 && (x.a3 != 0);
        e.nb_rd1   = (x.a1 == 0) ? 32'h0 : m_reg[x.a1];
        e.rd1      = (x.a1 == 0) ? 32'h0 : ((wr && x.a3 == x.a1) ? x.wd3 : m_reg[x.a1]);
        e.rd2      = (x.a2 == 0) ? 32'h0 : ((wr && x.a3 == x.a2) ? x.wd3 : m_reg[x.a2]);
        e.nb_busy1 = (x.a1 != 0) && m_busy[x.a1];
        e.busy1    = e.nb_busy1 && !(x.we3 && x.a3 == x.a1);
        e.busy2    = (x.a2 != 0) && m_busy[x.a2] && !(x.we3 && x.a3 == x.a2);
        e.rsv_ok   = (x.rsv_addr != 0) && !x.flush &&
                     (!m_busy[x.rsv_addr] || (x.we3 && x.a3 == x.rsv_addr));
        e.cnt      = m_cnt;
        return e;
    endfunction

    task automatic model_edge(input in_t x, input logic ok);
        int pc;
        if (x.we3 && x.a3 != 0) m_reg[x.a3] = x.wd3;
        if (x.flush) m_busy = '0;
        else begin
            if (x.we3) m_busy[x.a3] = 1'b0;
            if (x.rsv_en && ok) m_busy[x.rsv_addr] = 1'b1;
        end
        pc = 0;
        for (int k = 0; k < 32; k++) pc += m_busy[k];
        m_cnt = 6'(pc);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_reg[k] = '0;
        m_busy = '0;
        m_cnt  = '0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic drive(input in_t x);
        we3 = x.we3; a3 = x.a3; wd3 = x.wd3; a1 = x.a1; a2 = x.a2;
        rsv_en = x.rsv_en; rsv_addr = x.rsv_addr; flush = x.flush;
    endtask

    // Called just after a falling edge; leaves just after the next one.
    task automatic run_vec(input in_t x, input exp_t e, input string tag);
        exp_t got;
        exp_t m;
        drive(x);
        m = model_exp(x);
        #2;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        chk({tag, ".rd1"},    rd1,      got.rd1);
        chk({tag, ".rd2"},    rd2,      got.rd2);
        chk({tag, ".busy1"},  32'(busy1),  32'(got.busy1));
        chk({tag, ".busy2"},  32'(busy2),  32'(got.busy2));
        chk({tag, ".rsv_ok"}, 32'(rsv_ok), 32'(got.rsv_ok));
        chk({tag, ".cnt"},    32'(busy_cnt), 32'(got.cnt));
        chk({tag, ".nb_rd1"}, nb_rd1,   got.nb_rd1);
        chk({tag, ".nb_busy1"}, 32'(nb_busy1), 32'(got.nb_busy1));
        @(posedge clk);
        model_edge(x, m.rsv_ok);
        @(negedge clk);
    endtask

    task automatic run_m(input in_t x, input string tag);
        run_vec(x, model_exp(x), tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(0,0,32'h0,        0,0, 0,1,0, 32'h0,32'h0,0,0,1,0,32'h0,0);
        tbl[1]  = mk(1,7,32'h12345678, 7,0, 0,1,0, 32'h12345678,32'h0,0,0,1,0,32'h0,0);
        tbl[2]  = mk(0,0,32'h0,        7,7, 0,1,0, 32'h12345678,32'h12345678,0,0,1,0,32'h12345678,0);
        tbl[3]  = mk(1,0,32'hFFFFFFFF, 0,7, 1,0,0, 32'h0,32'h12345678,0,0,0,0,32'h0,0);
        tbl[4]  = mk(0,0,32'h0,        0,0, 1,3,0, 32'h0,32'h0,0,0,1,0,32'h0,0);
        tbl[5]  = mk(0,0,32'h0,        3,4, 1,4,0, 32'h0,32'h0,1,0,1,1,32'h0,1);
        tbl[6]  = mk(0,0,32'h0,        3,4, 1,3,0, 32'h0,32'h0,1,1,0,2,32'h0,1);
        tbl[7]  = mk(1,3,32'hA5A50003, 3,4, 0,3,0, 32'hA5A50003,32'h0,0,1,1,2,32'h0,1);
        tbl[8]  = mk(0,0,32'h0,        3,4, 0,1,0, 32'hA5A50003,32'h0,0,1,1,1,32'hA5A50003,0);
        tbl[9]  = mk(0,0,32'h0,        9,4, 1,9,0, 32'h0,32'h0,0,1,1,1,32'h0,0);
        tbl[10] = mk(1,9,32'h99,       9,4, 1,9,0, 32'h99,32'h0,0,1,1,2,32'h0,1);
        tbl[11] = mk(0,0,32'h0,        9,4, 0,9,0, 32'h99,32'h0,1,1,0,2,32'h99,1);
        tbl[12] = mk(0,0,32'h0,        1,2, 1,1,0, 32'h0,32'h0,0,0,1,2,32'h0,0);
        tbl[13] = mk(0,0,32'h0,        1,2, 1,2,0, 32'h0,32'h0,1,0,1,3,32'h0,1);
        tbl[14] = mk(0,0,32'h0,        1,2, 1,3,0, 32'h0,32'h0,1,1,1,4,32'h0,1);
        tbl[15] = mk(1,2,32'h55,       2,4, 1,4,1, 32'h55,32'h0,0,1,0,5,32'h0,1);
        tbl[16] = mk(0,0,32'h0,        2,4, 0,4,0, 32'h55,32'h0,0,0,1,0,32'h55,0);
        tbl[17] = mk(0,0,32'h0,        3,9, 0,9,0, 32'hA5A50003,32'h99,0,0,1,0,32'hA5A50003,0);

        // Power-on reset
        rst_n = 1'b0;
        drive(mkin(0,0,0, 5,0, 0,1,0));
        model_reset();
        #2;
        chk("por.rd1",    rd1, 32'h0);
        chk("por.cnt",    32'(busy_cnt), 32'h0);
        chk("por.rsv_ok", 32'(rsv_ok), 32'h1);
        chk("por.busy1",  32'(busy1), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 18; i++)
            run_vec(tbl[i].i, tbl[i].e, $sformatf("vec%0d", i));

        // Mid-run reset after writing r5 and reserving r6
        run_m(mkin(1,5,32'hDEADBEEF, 0,0, 1,6,0), "pre_rst_wr");
        run_m(mkin(0,0,32'h0, 5,6, 0,6,0), "pre_rst_rd");
        chk("pre_rst.cnt", 32'(busy_cnt), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.rd1",    rd1, 32'h0);
        chk("rst.rd2",    rd2, 32'h0);
        chk("rst.busy2",  32'(busy2), 32'h0);
        chk("rst.cnt",    32'(busy_cnt), 32'h0);
        chk("rst.rsv_ok", 32'(rsv_ok), 32'h1);
        chk("rst.nb_rd1", nb_rd1, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Reserve every register: count tops out at NREGS-1
        for (int r = 1; r < 32; r++)
            run_m(mkin(0,0,32'h0, 5'(r), 5'($urandom_range(0,31)), 1, 5'(r), 0),
                  $sformatf("fill%0d", r));
        drive(mkin(0,0,32'h0, 0,0, 1,17,0));
        #2;
        chk("full.cnt",    32'(busy_cnt), 32'd31);
        chk("full.rsv_ok", 32'(rsv_ok), 32'h0);
        @(negedge clk);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_t x;
            x.we3      = ($urandom_range(0,1) == 1);
            x.a3       = 5'($urandom_range(0,31));
            x.wd3      = $urandom;
            x.a1       = ($urandom_range(0,3) == 0) ? x.a3 : 5'($urandom_range(0,31));
            x.a2       = ($urandom_range(0,3) == 0) ? x.a3 : 5'($urandom_range(0,31));
            x.rsv_en   = ($urandom_range(0,3) != 0);
            x.rsv_addr = ($urandom_range(0,5) == 0) ? x.a3 : 5'($urandom_range(0,31));
            x.flush    = ($urandom_range(0,23) == 0);
            run_m(x, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
